if_unit: RTL and testbench



---
 rtl/if_unit.sv | 134 +++++++++++++
 tb/tb_if_unit.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/if_unit.sv
// Instruction-fetch stage: owns the PC, picks the next fetch address
// and buffers redirects that land while fetch is held.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   ctrl_stall[4:0]            {wb,mem,ex,decode,fetch}; bit0 freezes pc
//   ctrl_pc_re / ctrl_pc       trap/mret redirect pulse and target
//   branch_miss / branch_correct_pc  EX mispredict pulse and target
//   bp_taken / bp_target       predictor result for the current pc
//   imem_ready                 memory returns data for imem_addr
//   imem_addr, imem_req        fetch address and request
//   pc, branch_taken, branch_predict_pc, branch_pc_re  to IF/ID
//   fetch_stall_req            memory not ready
//   redirect_pending           a buffered redirect is waiting
module if_unit #(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       ctrl_stall,
  input  logic             ctrl_pc_re,
  input  logic [WIDTH-1:0] ctrl_pc,
  input  logic             branch_miss,
  input  logic [WIDTH-1:0] branch_correct_pc,
  input  logic             bp_taken,
  input  logic [WIDTH-1:0] bp_target,
  input  logic             imem_ready,
  output logic [WIDTH-1:0] imem_addr,
  output logic             imem_req,
  output logic [WIDTH-1:0] pc,
  output logic             branch_taken,
  output logic [WIDTH-1:0] branch_predict_pc,
  output logic             branch_pc_re,
  output logic             fetch_stall_req,
  output logic             redirect_pending
);

  typedef enum logic {
    RUN,
    PEND
  } state_t;

  localparam logic [WIDTH-1:0] ALIGN =
    {{(WIDTH-2){1'b1}}, 2'b00};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] pend_pc_q, pend_pc_d;
  logic             pend_trap_q, pend_trap_d;
  logic             re_q, re_d;

  logic             hold;
  logic             redir;
  logic [WIDTH-1:0] redir_pc;
  logic [WIDTH-1:0] bp_pc;
  logic [WIDTH-1:0] seq_pc;

  assign imem_req          = ~rst;
  assign imem_addr         = pc_q;
  assign pc                = pc_q;
  assign fetch_stall_req   = imem_req & ~imem_ready;
  assign branch_taken      = bp_taken & imem_req;
  assign branch_predict_pc = bp_target;
  assign branch_pc_re      = re_q;
  assign redirect_pending  = (state_q == PEND);

  assign hold     = ctrl_stall[0] | fetch_stall_req;
  assign redir    = ctrl_pc_re | branch_miss;
  // trap outranks a same-cycle miss
  assign redir_pc = (ctrl_pc_re ? ctrl_pc
                                : branch_correct_pc) & ALIGN;
  assign bp_pc    = bp_target & ALIGN;
  assign seq_pc   = pc_q + WIDTH'(4);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pend_pc_d   = pend_pc_q;
    pend_trap_d = pend_trap_q;
    re_d        = 1'b0;
    unique case (state_q)
      RUN: begin
        unique case (1'b1)
          redir && !hold: begin
            pc_d = redir_pc;
            re_d = 1'b1;
          end
          redir && hold: begin
            pend_pc_d   = redir_pc;
            pend_trap_d = ctrl_pc_re;
            state_d     = PEND;
          end
          !redir && !hold: begin
            pc_d = bp_taken ? bp_pc : seq_pc;
          end
          default: ;
        endcase
      end
      PEND: begin
        // a buffered trap is never displaced by a miss
        if (ctrl_pc_re) begin
          pend_pc_d   = redir_pc;
          pend_trap_d = 1'b1;
        end else if (branch_miss && !pend_trap_q) begin
          pend_pc_d = redir_pc;
        end
        if (!hold) begin
          pc_d    = pend_pc_d;
          re_d    = 1'b1;
          state_d = RUN;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      pc_q        <= RESET_PC;
      pend_pc_q   <= '0;
      pend_trap_q <= 1'b0;
      re_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pend_pc_q   <= pend_pc_d;
      pend_trap_q <= pend_trap_d;
      re_q        <= re_d;
    end
  end

endmodule

// File: tb/tb_if_unit.sv
// Scoreboard bench for if_unit: directed scenarios then random
// traffic, checked against a behavioural fetch model.
module tb_if_unit;

  logic        clk = 1'b1;
  logic        rst;
  logic [4:0]  ctrl_stall;
  logic        ctrl_pc_re;
  logic [31:0] ctrl_pc;
  logic        branch_miss;
  logic [31:0] branch_correct_pc;
  logic        bp_taken;
  logic [31:0] bp_target;
  logic        imem_ready;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic [31:0] pc;
  logic        branch_taken;
  logic [31:0] branch_predict_pc;
  logic        branch_pc_re;
  logic        fetch_stall_req;
  logic        redirect_pending;

  always #5 clk = ~clk;

  if_unit #(.WIDTH(32), .RESET_PC(32'h0)) dut (
    .clk               (clk),
    .rst               (rst),
    .ctrl_stall        (ctrl_stall),
    .ctrl_pc_re        (ctrl_pc_re),
    .ctrl_pc           (ctrl_pc),
    .branch_miss       (branch_miss),
    .branch_correct_pc (branch_correct_pc),
    .bp_taken          (bp_taken),
    .bp_target         (bp_target),
    .imem_ready        (imem_ready),
    .imem_addr         (imem_addr),
    .imem_req          (imem_req),
    .pc                (pc),
    .branch_taken      (branch_taken),
    .branch_predict_pc (branch_predict_pc),
    .branch_pc_re      (branch_pc_re),
    .fetch_stall_req   (fetch_stall_req),
    .redirect_pending  (redirect_pending)
  );

  typedef struct {
    bit          rst;
    bit [4:0]    stall;
    bit          trap;
    bit [31:0]   tpc;
    bit          miss;
    bit [31:0]   mpc;
    bit          bpg;
    bit [31:0]   bpt;
    bit          rdy;
  } stim_t;

  typedef struct {
    int        cyc;
    bit        rst;
    bit [31:0] pc;
    bit        re;
    bit        pend;
    bit        req;
    bit        fstall;
    bit        taken;
    bit [31:0] bpp;
  } exp_t;

  exp_t q[$];
  int compared = 0;
  int mismatched = 0;
  int cyc_n = 0;

  // reference model state
  bit [31:0] m_pc;
  bit        m_re;
  bit        m_pend;
  bit [31:0] m_ppc;
  bit        m_ptrap;

  function automatic stim_t idle();
    stim_t s;
    s = '{default: '0};
    s.rdy = 1'b1;
    return s;
  endfunction

  task automatic chk(input string n, input int c,
                     input logic [31:0] a,
                     input logic [31:0] e);
    compared++;
    if (a !== e) begin
      mismatched++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", n, c, a, e);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("imem_req", e.cyc, 32'(imem_req), 32'(e.req));
      chk("fstall", e.cyc, 32'(fetch_stall_req),
          32'(e.fstall));
      chk("taken", e.cyc, 32'(branch_taken), 32'(e.taken));
      if (!e.rst) begin
        chk("pc", e.cyc, pc, e.pc);
        chk("addr", e.cyc, imem_addr, e.pc);
        chk("pc_re", e.cyc, 32'(branch_pc_re), 32'(e.re));
        chk("pending", e.cyc, 32'(redirect_pending),
            32'(e.pend));
        chk("bp_pc", e.cyc, branch_predict_pc, e.bpp);
      end
    end
  end

  task automatic cyc(input stim_t s);
    exp_t      e;
    bit        hold;
    bit [31:0] t;
    rst               = s.rst;
    ctrl_stall        = s.stall;
    ctrl_pc_re        = s.trap;
    ctrl_pc           = s.tpc;
    branch_miss       = s.miss;
    branch_correct_pc = s.mpc;
    bp_taken          = s.bpg;
    bp_target         = s.bpt;
    imem_ready        = s.rdy;
    e.cyc    = cyc_n;
    e.rst    = s.rst;
    e.pc     = m_pc;
    e.re     = m_re;
    e.pend   = m_pend;
    e.req    = !s.rst;
    e.fstall = !s.rst && !s.rdy;
    e.taken  = !s.rst && s.bpg;
    e.bpp    = s.bpt;
    q.push_back(e);
    @(posedge clk);
    cyc_n++;
    // next-cycle model state
    hold = s.stall[0] || !s.rdy;
    if (s.rst) begin
      m_pc = 32'h0; m_re = 0; m_pend = 0;
      m_ppc = 0; m_ptrap = 0;
    end else if (!m_pend) begin
      m_re = 0;
      if (s.trap || s.miss) begin
        t = (s.trap ? s.tpc : s.mpc) & 32'hFFFF_FFFC;
        if (hold) begin
          m_pend = 1; m_ppc = t; m_ptrap = s.trap;
        end else begin
          m_pc = t; m_re = 1;
        end
      end else if (!hold) begin
        m_pc = s.bpg ? (s.bpt & 32'hFFFF_FFFC) : m_pc + 4;
      end
    end else begin
      if (s.trap) begin
        m_ppc = s.tpc & 32'hFFFF_FFFC; m_ptrap = 1;
      end else if (s.miss && !m_ptrap) begin
        m_ppc = s.mpc & 32'hFFFF_FFFC;
      end
      m_re = 0;
      if (!hold) begin
        m_pc = m_ppc; m_re = 1; m_pend = 0;
      end
    end
    #1;
  endtask

  initial begin
    stim_t s;
    m_pc = 0; m_re = 0; m_pend = 0; m_ppc = 0; m_ptrap = 0;
    #1;
    s = idle(); s.rst = 1;
    repeat (2) cyc(s);
    // sequential 0,4,8,C
    s = idle();
    repeat (4) cyc(s);
    // predictor taken at 0x10
    s = idle(); s.bpg = 1; s.bpt = 32'h40;
    cyc(s);
    cyc(idle());
    // unstalled miss
    s = idle(); s.miss = 1; s.mpc = 32'h200;
    cyc(s);
    repeat (2) cyc(idle());
    // miss during a 3-cycle stall
    s = idle(); s.stall = 5'b00001;
    s.miss = 1; s.mpc = 32'h300;
    cyc(s);
    s.miss = 0;
    repeat (2) cyc(s);
    repeat (2) cyc(idle());
    // trap and miss together
    s = idle(); s.trap = 1; s.tpc = 32'h800;
    s.miss = 1; s.mpc = 32'h300;
    cyc(s);
    cyc(idle());
    // miss cannot displace a pending trap
    s = idle(); s.stall = 5'b00001;
    s.trap = 1; s.tpc = 32'h800;
    cyc(s);
    s = idle(); s.stall = 5'b00001;
    s.miss = 1; s.mpc = 32'h300;
    cyc(s);
    repeat (2) cyc(idle());
    // memory not ready at 0x20
    s = idle(); s.trap = 1; s.tpc = 32'h20;
    cyc(s);
    s = idle(); s.rdy = 0;
    repeat (2) cyc(s);
    repeat (2) cyc(idle());
    // wrap from 0xFFFF_FFFC
    s = idle(); s.trap = 1; s.tpc = 32'hFFFF_FFFF;
    cyc(s);
    repeat (2) cyc(idle());
    // reset while pending
    s = idle(); s.stall = 5'b00001;
    s.miss = 1; s.mpc = 32'h500;
    cyc(s);
    s.miss = 0;
    cyc(s);
    s.rst = 1;
    cyc(s);
    repeat (2) cyc(idle());
    // random traffic
    for (int i = 0; i < 500; i++) begin
      s.rst   = ($urandom_range(0, 99) == 0);
      s.stall = 5'($urandom);
      s.stall[0] = ($urandom_range(0, 3) == 0);
      s.trap  = ($urandom_range(0, 15) == 0);
      s.tpc   = $urandom;
      s.miss  = ($urandom_range(0, 9) == 0);
      s.mpc   = $urandom;
      s.bpg   = ($urandom_range(0, 4) == 0);
      s.bpt   = $urandom;
      s.rdy   = ($urandom_range(0, 4) != 0);
      cyc(s);
    end
    cyc(idle());
    for (int i = 0; i < 10 && q.size() > 0; i++)
      @(posedge clk);
    if (q.size() > 0) begin
      mismatched++;
      $display("FAIL drain got=%0d exp=0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
